maze_collision_checker: RTL and testbench

- Produces the `collision` input consumed by the player movement stage.
- Works in screen-timing coordinates and uses the current room index: `x_pos`/`y_pos` and the room coordinates come from the player stage.
- Each check reads the wall-tile map for the four corners of the player sprite's bounding box and registers a single collision flag.
- The wall map is an external synchronous 1-bit ROM.

---
 rtl/maze_collision_checker.sv | 162 ++++++++++++++++
 tb/tb_maze_collision_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_collision_checker.sv
// Four-corner wall test for the player sprite against a synchronous 1-bit wall ROM.
// One check takes six cycles: latch, four corner reads (1-cycle ROM latency), finish.
`timescale 1ns/1ps
module maze_collision_checker #(
  parameter int H_ORIGIN    = 144,
  parameter int V_ORIGIN    = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPRITE_SIZE = 16,
  parameter int TILE_SHIFT  = 4
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic [2:0]  mapa_x,
  input  logic [2:0]  mapa_y,
  output logic [16:0] rom_addr,
  output logic        rom_rd,
  input  logic        rom_data,
  output logic        collision,
  output logic        check_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  mx_q, mx_d, my_q, my_d;
  logic [3:0]  mask_q, mask_d;
  logic        acc_q, acc_d;
  logic [16:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        coll_q, coll_d;
  logic        done_q, done_d;

  // Result is {inside, rom address}; 11-bit corner math so x+15 never wraps.
  function automatic logic [17:0] corner_f(input logic [9:0] x, input logic [9:0] y,
                                           input logic [2:0] mx, input logic [2:0] my,
                                           input logic [1:0] k);
    logic [10:0] cx, cy;
    logic        in_x, in_y;
    logic [5:0]  col;
    logic [4:0]  row;
    cx   = {1'b0, x} + (k[0] ? 11'(SPRITE_SIZE - 1) : 11'd0);
    cy   = {1'b0, y} + (k[1] ? 11'(SPRITE_SIZE - 1) : 11'd0);
    in_x = (cx >= 11'(H_ORIGIN)) && (cx < 11'(H_ORIGIN + H_ACTIVE));
    in_y = (cy >= 11'(V_ORIGIN)) && (cy < 11'(V_ORIGIN + V_ACTIVE));
    col  = 6'((cx - 11'(H_ORIGIN)) >> TILE_SHIFT);
    row  = 5'((cy - 11'(V_ORIGIN)) >> TILE_SHIFT);
    return {in_x && in_y, my, mx, row, col};
  endfunction

  logic [17:0] c0_new, c1_lat, c2_lat, c3_lat;

  // Corner 0 is addressed on the latch edge itself, so it comes from the live inputs.
  assign c0_new = corner_f(x_pos, y_pos, mapa_x, mapa_y, 2'd0);
  assign c1_lat = corner_f(x_q, y_q, mx_q, my_q, 2'd1);
  assign c2_lat = corner_f(x_q, y_q, mx_q, my_q, 2'd2);
  assign c3_lat = corner_f(x_q, y_q, mx_q, my_q, 2'd3);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mx_d    = mx_q;
    my_d    = my_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    coll_d  = coll_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RD0;
          x_d     = x_pos;
          y_d     = y_pos;
          mx_d    = mapa_x;
          my_d    = mapa_y;
          acc_d   = 1'b0;
          mask_d  = {3'b000, c0_new[17]};
          addr_d  = c0_new[16:0];
          rd_d    = c0_new[17];
        end
      end
      S_RD0: begin
        state_d   = S_RD1;
        mask_d[1] = c1_lat[17];
        addr_d    = c1_lat[16:0];
        rd_d      = c1_lat[17];
      end
      S_RD1: begin
        state_d   = S_RD2;
        acc_d     = acc_q | (rom_data & mask_q[0]);
        mask_d[2] = c2_lat[17];
        addr_d    = c2_lat[16:0];
        rd_d      = c2_lat[17];
      end
      S_RD2: begin
        state_d   = S_RD3;
        acc_d     = acc_q | (rom_data & mask_q[1]);
        mask_d[3] = c3_lat[17];
        addr_d    = c3_lat[16:0];
        rd_d      = c3_lat[17];
      end
      S_RD3: begin
        state_d = S_FIN;
        acc_d   = acc_q | (rom_data & mask_q[2]);
      end
      S_FIN: begin
        state_d = S_IDLE;
        coll_d  = acc_q | (rom_data & mask_q[3]);
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      mask_q  <= '0;
      acc_q   <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      coll_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      coll_q  <= coll_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr   = addr_q;
  assign rom_rd     = rd_q;
  assign collision  = coll_q;
  assign check_done = done_q;

endmodule

// File: tb/tb_maze_collision_checker.sv
// Bench for maze_collision_checker: vector table, hand sequences and random checks
// against a tile-arithmetic reference model over a behavioural wall ROM.
`timescale 1ns/1ps
module tb_maze_collision_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  x_pos = '0, y_pos = '0;
  logic [2:0]  mapa_x = '0, mapa_y = '0;
  logic [16:0] rom_addr;
  logic        rom_rd;
  logic        rom_data = 1'b0;
  logic        collision, check_done;

  always #20 clk = ~clk;

  maze_collision_checker dut (
    .CLOCK_25(clk), .reset(rst_n), .enable(enable),
    .x_pos(x_pos), .y_pos(y_pos), .mapa_x(mapa_x), .mapa_y(mapa_y),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .collision(collision), .check_done(check_done)
  );

  // Unstrobed cycles return 1 so any unmasked outside corner shows up as a wall.
  bit rom_mem [0:131071];
  always @(posedge clk) rom_data <= rom_rd ? rom_mem[rom_addr] : 1'b1;

  int n_checks = 0;
  int n_fail = 0;
  logic [16:0] got_addr [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_inside(input int cx, input int cy);
    return (cx >= 144) && (cx < 784) && (cy >= 35) && (cy < 515);
  endfunction

  function automatic int m_addr(input int cx, input int cy, input int mx, input int my);
    return my * 16384 + mx * 2048 + ((cy - 35) / 16) * 64 + (cx - 144) / 16;
  endfunction

  function automatic bit m_coll(input int x, input int y, input int mx, input int my);
    bit hit = 0;
    for (int k = 0; k < 4; k++) begin
      int cx = x + (k % 2) * 15;
      int cy = y + (k / 2) * 15;
      if (m_inside(cx, cy) && rom_mem[m_addr(cx, cy, mx, my)]) hit = 1;
    end
    return hit;
  endfunction

  function automatic void rom_clear();
    foreach (rom_mem[i]) rom_mem[i] = 0;
  endfunction

  // One full check from IDLE; inputs are scrambled after the latch edge.
  task automatic do_check(input int x, input int y, input int mx, input int my, input string tag);
    @(negedge clk);
    x_pos = 10'(x); y_pos = 10'(y); mapa_x = 3'(mx); mapa_y = 3'(my); enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    x_pos = 10'($urandom); y_pos = 10'($urandom);
    mapa_x = 3'($urandom); mapa_y = 3'($urandom);
    for (int k = 0; k < 4; k++) begin
      int cx = x + (k % 2) * 15;
      int cy = y + (k / 2) * 15;
      bit in = m_inside(cx, cy);
      got_addr[k] = rom_addr;
      chk({tag, " rd"}, 32'(rom_rd), 32'(in));
      if (in) chk({tag, " addr"}, 32'(rom_addr), 32'(m_addr(cx, cy, mx, my)));
      @(negedge clk);
    end
    chk({tag, " fin rd"}, 32'(rom_rd), 32'd0);
    chk({tag, " fin done"}, 32'(check_done), 32'd0);
    @(negedge clk);
    chk({tag, " done"}, 32'(check_done), 32'd1);
    chk({tag, " coll"}, 32'(collision), 32'(m_coll(x, y, mx, my)));
  endtask

  typedef struct {
    int x; int y; int mx; int my;
    bit exp_coll;
  } vec_t;

  vec_t vecs [9];
  int done_at [$];

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{144, 35, 0, 7, 1'b1};
    vecs[1] = '{439, 266, 0, 7, 1'b1};
    vecs[2] = '{439, 266, 1, 7, 1'b0};
    vecs[3] = '{128, 35, 0, 7, 1'b0};
    vecs[4] = '{129, 35, 0, 7, 1'b1};
    vecs[5] = '{144, 20, 0, 7, 1'b1};
    vecs[6] = '{433, 260, 0, 7, 1'b1};
    vecs[7] = '{432, 259, 0, 7, 1'b0};
    vecs[8] = '{776, 500, 0, 7, 1'b0};

    rom_clear();
    #5;
    chk("reset coll", 32'(collision), 32'd0);
    chk("reset done", 32'(check_done), 32'd0);
    chk("reset rd", 32'(rom_rd), 32'd0);
    chk("reset addr", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Test 1
    rom_mem[17'h1C000] = 1;
    do_check(144, 35, 0, 7, "t1");
    chk("t1 addr0", 32'(got_addr[0]), 32'h1C000);

    // Test 2
    rom_clear();
    do_check(439, 266, 0, 7, "t2a");
    chk("t2 addr0", 32'(got_addr[0]), 32'h1C392);
    chk("t2 addr1", 32'(got_addr[1]), 32'h1C393);
    chk("t2 addr2", 32'(got_addr[2]), 32'h1C3D2);
    chk("t2 addr3", 32'(got_addr[3]), 32'h1C3D3);
    chk("t2a coll0", 32'(collision), 32'd0);
    rom_mem[17'h1C3D3] = 1;
    do_check(439, 266, 0, 7, "t2b");
    chk("t2b coll1", 32'(collision), 32'd1);

    // Test 3: all corners left of the screen, ROM full of walls
    foreach (rom_mem[i]) rom_mem[i] = 1;
    do_check(128, 35, 0, 7, "t3");
    chk("t3 coll0", 32'(collision), 32'd0);

    // Vector table against walls at 0x1C000 and 0x1C3D3
    rom_clear();
    rom_mem[17'h1C000] = 1;
    rom_mem[17'h1C3D3] = 1;
    for (int i = 0; i < 9; i++) begin
      do_check(vecs[i].x, vecs[i].y, vecs[i].mx, vecs[i].my, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table", i), 32'(collision), 32'(vecs[i].exp_coll));
    end

    // Test 4: reset during S_RD2 of a colliding check
    do_check(144, 35, 0, 7, "t4pre");
    @(negedge clk);
    x_pos = 10'd144; y_pos = 10'd35; mapa_x = 3'd0; mapa_y = 3'd7; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4 coll", 32'(collision), 32'd0);
    chk("t4 rd", 32'(rom_rd), 32'd0);
    chk("t4 done", 32'(check_done), 32'd0);
    chk("t4 addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4 idle rd", 32'(rom_rd), 32'd0);
      chk("t4 idle done", 32'(check_done), 32'd0);
    end
    do_check(144, 35, 0, 7, "t4post");

    // Test 5: continuous enable, x changed mid-check, enable dropped mid third check
    rom_clear();
    rom_mem[17'h1C000] = 1;
    @(negedge clk);
    x_pos = 10'd144; y_pos = 10'd35; mapa_x = 3'd0; mapa_y = 3'd7; enable = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (check_done) done_at.push_back(n);
      if (n == 1) chk("t5 addr c0 first", 32'(rom_addr), 32'h1C000);
      if (n == 2) x_pos = 10'd208;
      if (n == 6) chk("t5 coll first", 32'(collision), 32'd1);
      if (n == 7) chk("t5 addr c0 second", 32'(rom_addr), 32'h1C004);
      if (n == 12) chk("t5 coll second", 32'(collision), 32'd0);
      if (n == 13) begin
        chk("t5 addr c0 third", 32'(rom_addr), 32'h1C004);
        enable = 1'b0;
      end
    end
    chk("t5 pulse count", 32'(done_at.size()), 32'd3);
    if (done_at.size() == 3) begin
      chk("t5 pulse1", 32'(done_at[0]), 32'd6);
      chk("t5 pulse2", 32'(done_at[1]), 32'd12);
      chk("t5 pulse3", 32'(done_at[2]), 32'd18);
    end

    // Test 6: idle after a hit holds the result
    do_check(144, 35, 0, 7, "t6pre");
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("t6 rd", 32'(rom_rd), 32'd0);
      chk("t6 done", 32'(check_done), 32'd0);
      chk("t6 coll", 32'(collision), 32'd1);
    end

    // Random checks against the model over a random wall map
    foreach (rom_mem[i]) rom_mem[i] = ($urandom_range(0, 99) < 30);
    for (int i = 0; i < 60; i++) begin
      do_check($urandom_range(100, 800), $urandom_range(10, 530),
               $urandom_range(0, 7), $urandom_range(0, 7), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
